// File: rtl/lab4_branch_gshare_spec.sv
// gshare direction predictor: speculative global history, mispredict recovery, PHT init sweep.
// Optional prediction/mispredict counters are enabled by defining BRANCH_GSHARE_STATS_EN.
module lab4_branch_gshare_spec #(
    parameter int PHT_SIZE  = 2048,
    parameter int HIST_BITS = 11,
    parameter int CTR_BITS  = 2,
    parameter int CTR_INIT  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    output logic                 ready,
    input  logic                 pred_val,
    input  logic [31:0]          pred_pc,
    output logic                 pred_taken,
    output logic [HIST_BITS-1:0] pred_hist,
    input  logic                 upd_en,
    input  logic [31:0]          upd_pc,
    input  logic [HIST_BITS-1:0] upd_hist,
    input  logic                 upd_taken,
    input  logic                 upd_mispred,
    output logic [31:0]          stat_npred,
    output logic [31:0]          stat_nmisp
);
    localparam int IDX = $clog2(PHT_SIZE);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
    localparam logic [IDX-1:0]      PTR_LAST = IDX'(PHT_SIZE - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state_reg;
    logic [IDX-1:0]       init_ptr_reg;
    logic [HIST_BITS-1:0] spec_hist_reg;
    logic [HIST_BITS-1:0] spec_hist_next;
    logic [CTR_BITS-1:0]  pht [PHT_SIZE];

    logic                 run;
    logic [IDX-1:0]       pred_idx;
    logic [IDX-1:0]       upd_idx;
    logic [CTR_BITS-1:0]  pred_ctr;
    logic [CTR_BITS-1:0]  upd_ctr;
    logic [CTR_BITS-1:0]  upd_ctr_next;
    logic                 pred_fire;
    logic                 upd_fire;
    logic                 recover;

    assign run       = (state_reg == ST_RUN);
    assign pred_idx  = pred_pc[IDX+1:2] ^ IDX'(spec_hist_reg);
    assign upd_idx   = upd_pc[IDX+1:2] ^ IDX'(upd_hist);
    assign pred_ctr  = pht[pred_idx];
    assign upd_ctr   = pht[upd_idx];
    assign pred_fire = run & pred_val & ~flush;
    assign upd_fire  = run & upd_en & ~flush;
    assign recover   = upd_fire & upd_mispred;

    assign ready      = run;
    assign pred_taken = run & pred_ctr[CTR_BITS-1];
    assign pred_hist  = run ? spec_hist_reg : '0;

    // Saturating counter step; never wraps in either direction.
    always_comb begin
        upd_ctr_next = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + CTR_ONE;
        end else begin
            if (upd_ctr != CTR_ZERO) upd_ctr_next = upd_ctr - CTR_ONE;
        end
    end

    // Recovery restores the resolved branch's history and beats a same-cycle predict shift.
    always_comb begin
        spec_hist_next = spec_hist_reg;
        if (recover)
            spec_hist_next = HIST_BITS'({upd_hist, upd_taken});
        else if (pred_fire)
            spec_hist_next = HIST_BITS'({spec_hist_reg, pred_taken});
    end

    // Table has no reset: its contents are only trusted after the sweep completes.
    always_ff @(posedge clk) begin
        if (state_reg == ST_INIT)
            pht[init_ptr_reg] <= CTR_BITS'(CTR_INIT);
        else if (upd_fire)
            pht[upd_idx] <= upd_ctr_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_INIT;
            init_ptr_reg  <= '0;
            spec_hist_reg <= '0;
        end else if (flush) begin
            state_reg     <= ST_INIT;
            init_ptr_reg  <= '0;
            spec_hist_reg <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    if (init_ptr_reg == PTR_LAST)
                        state_reg <= ST_RUN;
                    else
                        init_ptr_reg <= init_ptr_reg + IDX'(1);
                end
                ST_RUN: spec_hist_reg <= spec_hist_next;
                default: state_reg <= ST_INIT;
            endcase
        end
    end

`ifdef BRANCH_GSHARE_STATS_EN
    logic [31:0] stat_npred_reg;
    logic [31:0] stat_nmisp_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_npred_reg <= '0;
            stat_nmisp_reg <= '0;
        end else if (flush) begin
            stat_npred_reg <= '0;
            stat_nmisp_reg <= '0;
        end else begin
            if (pred_fire) stat_npred_reg <= stat_npred_reg + 32'd1;
            if (recover)   stat_nmisp_reg <= stat_nmisp_reg + 32'd1;
        end
    end

    assign stat_npred = stat_npred_reg;
    assign stat_nmisp = stat_nmisp_reg;
`else
    assign stat_npred = '0;
    assign stat_nmisp = '0;
`endif

    // PC bits outside the index field do not participate.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:IDX+2], pred_pc[1:0], upd_pc[31:IDX+2], upd_pc[1:0]};

endmodule

// File: tb/tb_lab4_branch_gshare_spec.sv
// Bench for lab4_branch_gshare_spec: directed vector table, hand sequences for flush/reset,
// and randomized traffic checked against an integer-arithmetic model of the predictor.
module tb_lab4_branch_gshare_spec;
    localparam int PHT = 16;
    localparam int HB  = 4;
    localparam int CB  = 2;
    localparam int CI  = 1;
    localparam int HMASK = (1 << HB) - 1;
    localparam int CMAX  = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          ready;
    logic          pred_val = 1'b0;
    logic [31:0]   pred_pc = '0;
    logic          pred_taken;
    logic [HB-1:0] pred_hist;
    logic          upd_en = 1'b0;
    logic [31:0]   upd_pc = '0;
    logic [HB-1:0] upd_hist = '0;
    logic          upd_taken = 1'b0;
    logic          upd_mispred = 1'b0;
    logic [31:0]   stat_npred;
    logic [31:0]   stat_nmisp;

    lab4_branch_gshare_spec #(
        .PHT_SIZE(PHT), .HIST_BITS(HB), .CTR_BITS(CB), .CTR_INIT(CI)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .ready(ready),
        .pred_val(pred_val), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_hist(pred_hist),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_hist(upd_hist), .upd_taken(upd_taken),
        .upd_mispred(upd_mispred), .stat_npred(stat_npred), .stat_nmisp(stat_nmisp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_pht [PHT];
    bit          m_run;
    int          m_left;
    int          m_hist;
    logic [31:0] m_npred;
    logic [31:0] m_nmisp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc, input int h);
        return (int'(pc >> 2) & (PHT - 1)) ^ h;
    endfunction

    task automatic m_reset();
        m_run   = 1'b0;
        m_left  = PHT;
        m_hist  = 0;
        m_npred = '0;
        m_nmisp = '0;
    endtask

    task automatic m_edge();
        int pt;
        int u;
        if (!reset_n || flush) begin
            m_reset();
        end else if (!m_run) begin
            m_left--;
            if (m_left == 0) begin
                m_run = 1'b1;
                foreach (m_pht[i]) m_pht[i] = CI;
            end
        end else begin
            pt = (m_pht[m_idx(pred_pc, m_hist)] > CMAX / 2) ? 1 : 0;
            if (upd_en) begin
                u = m_idx(upd_pc, int'(upd_hist));
                if (upd_taken) m_pht[u] = (m_pht[u] == CMAX) ? CMAX : m_pht[u] + 1;
                else           m_pht[u] = (m_pht[u] == 0) ? 0 : m_pht[u] - 1;
            end
            if (upd_en && upd_mispred) begin
                m_hist = ((int'(upd_hist) << 1) | int'(upd_taken)) & HMASK;
                m_nmisp = m_nmisp + 32'd1;
            end else if (pred_val) begin
                m_hist = ((m_hist << 1) | pt) & HMASK;
            end
            if (pred_val) m_npred = m_npred + 32'd1;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_np;
        logic [31:0] exp_nm;
        int et;
        et = (m_run && m_pht[m_idx(pred_pc, m_hist)] > CMAX / 2) ? 1 : 0;
`ifdef BRANCH_GSHARE_STATS_EN
        exp_np = m_npred;
        exp_nm = m_nmisp;
`else
        exp_np = '0;
        exp_nm = '0;
`endif
        check("ready", 32'(ready), 32'(m_run));
        check("pred_taken", 32'(pred_taken), 32'(et));
        check("pred_hist", 32'(pred_hist), m_run ? 32'(m_hist) : 32'd0);
        check("stat_npred", stat_npred, exp_np);
        check("stat_nmisp", stat_nmisp, exp_nm);
    endtask

    task automatic edge_model();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        edge_model();
    endtask

    task automatic idle_inputs();
        flush = 0; pred_val = 0; pred_pc = '0; upd_en = 0; upd_pc = '0;
        upd_hist = '0; upd_taken = 0; upd_mispred = 0;
    endtask

    typedef struct {
        logic          pv;
        logic [31:0]   ppc;
        logic          ue;
        logic [31:0]   upc;
        logic [HB-1:0] uh;
        logic          ut;
        logic          um;
        logic          et;
        logic [HB-1:0] eh;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // Training, history shifting, recovery and same-cycle read/write, starting from a fresh sweep.
        tbl[0]  = '{1'b0, 32'h40, 1'b1, 32'h40, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{1'b0, 32'h40, 1'b1, 32'h40, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0};
        tbl[2]  = '{1'b0, 32'h40, 1'b1, 32'h40, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0};
        tbl[3]  = '{1'b1, 32'h40, 1'b0, 32'h00, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0};
        tbl[4]  = '{1'b1, 32'h04, 1'b0, 32'h00, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1};
        tbl[5]  = '{1'b1, 32'h0C, 1'b0, 32'h00, 4'h0, 1'b0, 1'b0, 1'b1, 4'h3};
        tbl[6]  = '{1'b1, 32'h1C, 1'b0, 32'h00, 4'h0, 1'b0, 1'b0, 1'b1, 4'h7};
        tbl[7]  = '{1'b1, 32'h3C, 1'b0, 32'h00, 4'h0, 1'b0, 1'b0, 1'b1, 4'hF};
        tbl[8]  = '{1'b1, 32'h3C, 1'b1, 32'h00, 4'hA, 1'b0, 1'b1, 1'b1, 4'hF};
        tbl[9]  = '{1'b0, 32'h00, 1'b0, 32'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h4};
        tbl[10] = '{1'b0, 32'h10, 1'b1, 32'h00, 4'h0, 1'b0, 1'b0, 1'b1, 4'h4};
        tbl[11] = '{1'b0, 32'h10, 1'b1, 32'h00, 4'h0, 1'b0, 1'b0, 1'b1, 4'h4};
        tbl[12] = '{1'b0, 32'h10, 1'b0, 32'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h4};

        m_reset();
        foreach (m_pht[i]) m_pht[i] = 0;
        idle_inputs();
        reset_n = 0;
        repeat (2) step();
        reset_n = 1;

        // Sweep after reset: predictions requested during it must be ignored.
        for (int i = 0; i < PHT; i++) begin
            pred_val = 1;
            pred_pc  = $urandom;
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("ready_17th", 32'(ready), 32'd1);
        check("hist_after_sweep", 32'(pred_hist), 32'd0);
        edge_model();

        for (int i = 0; i < 13; i++) begin
            pred_val = tbl[i].pv; pred_pc = tbl[i].ppc; upd_en = tbl[i].ue; upd_pc = tbl[i].upc;
            upd_hist = tbl[i].uh; upd_taken = tbl[i].ut; upd_mispred = tbl[i].um;
            @(negedge clk);
            check_outputs();
            check($sformatf("tbl%0d_taken", i), 32'(pred_taken), 32'(tbl[i].et));
            check($sformatf("tbl%0d_hist", i), 32'(pred_hist), 32'(tbl[i].eh));
            $display("vec %0d: pc=0x%0h taken=%0b hist=%0h", i, pred_pc, pred_taken, pred_hist);
            edge_model();
        end
        idle_inputs();

        // Flush after training: 16-cycle sweep, then the trained entry predicts not-taken again.
        flush = 1;
        step();
        flush = 0;
        for (int i = 0; i < PHT; i++) step();
        pred_pc = 32'h40;
        @(negedge clk);
        check("flush_ready", 32'(ready), 32'd1);
        check("flush_pred0", 32'(pred_taken), 32'd0);
        check("flush_hist0", 32'(pred_hist), 32'd0);
        edge_model();

        // Reset mid-sweep restarts from entry 0.
        flush = 1;
        step();
        flush = 0;
        repeat (5) step();
        reset_n = 0;
        m_reset();
        @(negedge clk);
        check("rst_mid_ready", 32'(ready), 32'd0);
        edge_model();
        reset_n = 1;
        for (int i = 0; i < PHT; i++) step();
        @(negedge clk);
        check("rst_sweep_ready", 32'(ready), 32'd1);
        edge_model();

`ifdef BRANCH_GSHARE_STATS_EN
        // Counters cleared by the reset above; 5 predictions and 2 mispredicts.
        for (int i = 0; i < 5; i++) begin
            pred_val = 1; pred_pc = 32'(i * 4);
            upd_en = (i < 2); upd_mispred = (i < 2); upd_taken = 1; upd_pc = '0;
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("stats_npred5", stat_npred, 32'd5);
        check("stats_nmisp2", stat_nmisp, 32'd2);
        edge_model();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            flush       = ($urandom_range(0, 99) == 0);
            pred_val    = $urandom_range(0, 1);
            pred_pc     = $urandom;
            upd_en      = $urandom_range(0, 1);
            upd_pc      = $urandom;
            upd_hist    = HB'($urandom);
            upd_taken   = $urandom_range(0, 1);
            upd_mispred = ($urandom_range(0, 3) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
